// File: rtl/mips_instr_encoder_loader_if.sv
// Field stream and instruction-memory write port for the encoder/loader.
// master: the side that supplies fields and owns the memory; slave: the encoder.
interface mips_instr_encoder_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_kind;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target,
    input  in_ready,
    input  wr_valid, wr_addr, wr_data,
    output wr_ready
  );

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target,
    output in_ready,
    output wr_valid, wr_addr, wr_data,
    input  wr_ready
  );
endinterface

// File: rtl/mips_instr_encoder_loader.sv
// Packs decoded MIPS fields into 32-bit words and writes them to consecutive
// instruction-memory addresses, one holding register deep.
module mips_instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic                  finish,
  mips_instr_encoder_loader_if.slave bus,
  output logic                  busy,
  output logic                  done,
  output logic                  full,
  output logic                  err,
  output logic [ADDR_W:0]       word_count
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [ADDR_W+1:0] LIMIT = (ADDR_W+2)'(DEPTH);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   acc;
  logic              fin_pend;
  logic [ADDR_W+1:0] cur;
  logic              room, legal, accept, fill, wr_fire, full_now, open_sess;
  logic [31:0]       enc;

  // Extra headroom bits so base+acc never wraps before the DEPTH compare.
  assign cur       = {2'b00, base} + {1'b0, acc};
  assign room      = cur < LIMIT;
  assign legal     = bus.in_kind < 3'd6;
  assign bus.in_ready = (state == LOAD) && !fin_pend && room && (!bus.wr_valid || bus.wr_ready);
  assign accept    = bus.in_valid && bus.in_ready;
  assign fill      = accept && legal;
  assign wr_fire   = bus.wr_valid && bus.wr_ready;
  assign full_now  = full || !room;
  assign open_sess = start && (state != LOAD);

  assign busy = (state == LOAD);
  assign done = (state == DONE);

  // Field packing: inverse of the core's opcode decode.
  always_comb begin
    enc = '0;
    case (bus.in_kind)
      3'd0:    enc = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_funct};
      3'd1:    enc = {6'b001000, bus.in_rs, bus.in_rt, bus.in_imm};
      3'd2:    enc = {6'b100011, bus.in_rs, bus.in_rt, bus.in_imm};
      3'd3:    enc = {6'b101011, bus.in_rs, bus.in_rt, bus.in_imm};
      3'd4:    enc = {6'b000100, bus.in_rs, bus.in_rt, bus.in_imm};
      3'd5:    enc = {6'b000010, bus.in_target};
      default: enc = '0;
    endcase
  end

  // Next state: leave LOAD only once the last word has left the holding register.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    if ((fin_pend || full_now) && !bus.wr_valid) state_nx = DONE;
      DONE:    if (start) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Holding register, session counters and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.wr_valid <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
      base         <= '0;
      acc          <= '0;
      word_count   <= '0;
      fin_pend     <= 1'b0;
      full         <= 1'b0;
      err          <= 1'b0;
    end else begin
      if (wr_fire) begin
        bus.wr_valid <= 1'b0;
        word_count   <= word_count + (ADDR_W+1)'(1);
      end
      // A refill in the same cycle as a drain wins: keeps 1 word/cycle.
      if (fill) begin
        bus.wr_valid <= 1'b1;
        bus.wr_addr  <= cur[ADDR_W-1:0];
        bus.wr_data  <= enc;
        acc          <= acc + (ADDR_W+1)'(1);
      end
      if (accept && !legal) err <= 1'b1;
      if (state == LOAD) begin
        if (finish) fin_pend <= 1'b1;
        if (!room)  full     <= 1'b1;
      end
      // Holding register is empty outside LOAD, so no write can collide here.
      if (open_sess) begin
        base       <= start_addr;
        acc        <= '0;
        word_count <= '0;
        fin_pend   <= 1'b0;
        full       <= 1'b0;
        err        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder_loader.sv
// Directed bench for the MIPS encoder/loader: hand-computed words and addresses.
module tb_mips_instr_encoder_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic              finish;
  logic              busy, done, full, err;
  logic [ADDR_W:0]   word_count;

  int nchk = 0;
  int nerr = 0;

  logic [39:0] wlog [$];
  logic [31:0] exp_d [6];

  mips_instr_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

  mips_instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .finish(finish),
    .bus(bus), .busy(busy), .done(done), .full(full), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Record every completed write handshake.
  always @(posedge clk)
    if (!reset && bus.wr_valid && bus.wr_ready) wlog.push_back({bus.wr_addr, bus.wr_data});

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] a);
    wlog.delete();
    start = 1'b1; start_addr = a;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
  endtask

  task automatic send(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                      input logic [15:0] imm, input logic [25:0] tgt, input logic fin);
    logic took = 1'b0;
    bus.in_valid = 1'b1; bus.in_kind = k; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
    bus.in_shamt = sh; bus.in_funct = fn; bus.in_imm = imm; bus.in_target = tgt;
    finish = fin;
    for (int n = 0; n < 50 && !took; n++) begin
      #1 took = bus.in_ready;
      @(negedge clk);
      finish = 1'b0;
    end
    bus.in_valid = 1'b0;
    if (!took) chk("send_timeout", 40'd0, 40'd1);
  endtask

  task automatic wait_done(input string tag);
    for (int n = 0; n < 40 && !done; n++) @(negedge clk);
    chk(tag, {39'd0, done}, 40'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; start_addr = '0; finish = 1'b0;
    bus.in_valid = 1'b0; bus.in_kind = '0; bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0;
    bus.in_shamt = '0; bus.in_funct = '0; bus.in_imm = '0; bus.in_target = '0;
    bus.wr_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy",  {39'd0, busy}, 40'd0);
    chk("rst_done",  {39'd0, done}, 40'd0);
    chk("rst_full",  {39'd0, full}, 40'd0);
    chk("rst_err",   {39'd0, err}, 40'd0);
    chk("rst_wc",    40'(word_count), 40'd0);
    chk("rst_wrv",   {39'd0, bus.wr_valid}, 40'd0);
    chk("rst_rdy",   {39'd0, bus.in_ready}, 40'd0);
    reset = 1'b0;
    @(negedge clk);

    // Every legal kind, start address 0.
    exp_d = '{32'h00221820, 32'h20040005, 32'h8C250008, 32'hAC26000C, 32'h1043FFFE, 32'h08000010};
    pulse_start(8'd0);
    chk("seq_busy", {39'd0, busy}, 40'd1);
    send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b0);
    chk("seq_lat_v", {39'd0, bus.wr_valid}, 40'd1);
    chk("seq_lat_d", {8'd0, bus.wr_data}, {8'd0, exp_d[0]});
    send(3'd1, 5'd0, 5'd4, 5'd0, 5'd0, 6'h0, 16'h0005, 26'h0, 1'b0);
    send(3'd2, 5'd1, 5'd5, 5'd0, 5'd0, 6'h0, 16'h0008, 26'h0, 1'b0);
    send(3'd3, 5'd1, 5'd6, 5'd0, 5'd0, 6'h0, 16'h000C, 26'h0, 1'b0);
    send(3'd4, 5'd2, 5'd3, 5'd0, 5'd0, 6'h0, 16'hFFFE, 26'h0, 1'b0);
    send(3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0000010, 1'b0);
    pulse_finish();
    wait_done("seq_done");
    chk("seq_n", 40'(wlog.size()), 40'd6);
    for (int i = 0; i < 6 && i < wlog.size(); i++)
      chk($sformatf("seq_w%0d", i), wlog[i], {8'(i), exp_d[i]});
    chk("seq_wc",   40'(word_count), 40'd6);
    chk("seq_busy0", {39'd0, busy}, 40'd0);

    // Backpressure: two beats while the memory stalls for three cycles.
    pulse_start(8'd10);
    bus.wr_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_kind = 3'd1; bus.in_rs = 5'd0; bus.in_rt = 5'd1; bus.in_imm = 16'd1;
    #1 chk("bp_rdy_a", {39'd0, bus.in_ready}, 40'd1);
    @(negedge clk);
    bus.in_imm = 16'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_rdy%0d", i), {39'd0, bus.in_ready}, 40'd0);
      chk($sformatf("bp_v%0d", i),   {39'd0, bus.wr_valid}, 40'd1);
      chk($sformatf("bp_d%0d", i),   {8'd0, bus.wr_data}, 40'h0020010001);
      @(negedge clk);
    end
    bus.wr_ready = 1'b1;
    #1 chk("bp_rdy_b", {39'd0, bus.in_ready}, 40'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_d_b", {bus.wr_addr, bus.wr_data}, {8'd11, 32'h20010002});
    @(negedge clk);
    pulse_finish();
    wait_done("bp_done");
    chk("bp_n", 40'(wlog.size()), 40'd2);
    if (wlog.size() == 2) begin
      chk("bp_w0", wlog[0], {8'd10, 32'h20010001});
      chk("bp_w1", wlog[1], {8'd11, 32'h20010002});
    end
    chk("bp_wc", 40'(word_count), 40'd2);

    // Address limit: only 254 and 255 fit.
    pulse_start(8'd254);
    bus.in_valid = 1'b1; bus.in_kind = 3'd1; bus.in_rt = 5'd1; bus.in_imm = 16'd1;
    repeat (2) @(negedge clk);
    #1 chk("lim_rdy", {39'd0, bus.in_ready}, 40'd0);
    repeat (4) @(negedge clk);
    bus.in_valid = 1'b0;
    wait_done("lim_done");
    chk("lim_full", {39'd0, full}, 40'd1);
    chk("lim_n", 40'(wlog.size()), 40'd2);
    if (wlog.size() == 2) begin
      chk("lim_w0", wlog[0], {8'd254, 32'h20010001});
      chk("lim_w1", wlog[1], {8'd255, 32'h20010001});
    end
    chk("lim_wc", 40'(word_count), 40'd2);

    // Illegal kind in the middle is consumed but not written.
    pulse_start(8'd20);
    chk("ill_full0", {39'd0, full}, 40'd0);
    send(3'd1, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'd1, 26'h0, 1'b0);
    send(3'd7, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'd2, 26'h0, 1'b0);
    send(3'd1, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'd3, 26'h0, 1'b0);
    pulse_finish();
    wait_done("ill_done");
    chk("ill_err", {39'd0, err}, 40'd1);
    chk("ill_n", 40'(wlog.size()), 40'd2);
    if (wlog.size() == 2) begin
      chk("ill_w0", wlog[0], {8'd20, 32'h20010001});
      chk("ill_w1", wlog[1], {8'd21, 32'h20010003});
    end
    chk("ill_wc", 40'(word_count), 40'd2);

    // Finish in the same cycle as the final accepted beat.
    pulse_start(8'd30);
    chk("fin_err0", {39'd0, err}, 40'd0);
    send(3'd1, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'd7, 26'h0, 1'b1);
    bus.in_valid = 1'b1;
    #1 chk("fin_rdy", {39'd0, bus.in_ready}, 40'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_done("fin_done");
    chk("fin_n", 40'(wlog.size()), 40'd1);
    if (wlog.size() == 1) chk("fin_w0", wlog[0], {8'd30, 32'h20010007});
    chk("fin_wc", 40'(word_count), 40'd1);

    // Reset while a word is pending, then a fresh session.
    pulse_start(8'd40);
    bus.wr_ready = 1'b0;
    send(3'd1, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'd9, 26'h0, 1'b0);
    chk("mr_wrv1", {39'd0, bus.wr_valid}, 40'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_wrv0", {39'd0, bus.wr_valid}, 40'd0);
    chk("mr_busy", {39'd0, busy}, 40'd0);
    chk("mr_done", {39'd0, done}, 40'd0);
    chk("mr_wc",   40'(word_count), 40'd0);
    reset = 1'b0;
    bus.wr_ready = 1'b1;
    @(negedge clk);
    pulse_start(8'd50);
    chk("mr_busy1", {39'd0, busy}, 40'd1);
    send(3'd1, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'd9, 26'h0, 1'b0);
    pulse_finish();
    wait_done("mr_done2");
    chk("mr_n", 40'(wlog.size()), 40'd1);
    if (wlog.size() == 1) chk("mr_w0", wlog[0], {8'd50, 32'h20010009});

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/mips_instr_encoder_loader.md
Name: mips_instr_encoder_loader

Overview:
- Instruction encoder and loader for the single-cycle MIPS core; it performs the inverse of the core's opcode decode.
- Accepts decoded instruction fields (kind plus operands) over a valid/ready stream and packs them into 32-bit MIPS words.
- Writes the words to sequential instruction-memory addresses through a handshaked write port.
- Used by testbenches and the boot path to load programs before the core is released.

Parameters:
- ADDR_W, 8, width of instruction-memory word address.
- DEPTH, 256, number of instruction-memory words; must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: begin a load session at start_addr.
- start_addr  in  ADDR_W  first word address of the session.
- finish  in  1  one-cycle pulse: end of program; drain, then go to DONE.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  encoder can accept fields this cycle.
- in_kind  in  3  0 R-type, 1 addi, 2 lw, 3 sw, 4 beq, 5 j; 6 and 7 are illegal.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
- in_funct  in  6  R-type funct.
- in_imm  in  16  immediate / offset.
- in_target  in  26  jump target.
- wr_valid  out  1  wr_addr/wr_data valid.
- wr_ready  in  1  memory accepts the write.
- wr_addr  out  ADDR_W  word address.
- wr_data  out  32  encoded instruction.
- busy  out  1  state is LOAD.
- done  out  1  state is DONE.
- full  out  1  session ran out of addresses.
- err  out  1  sticky: an illegal kind was seen this session.
- word_count  out  ADDR_W+1  words written (wr handshakes) this session.

Behaviour:
- Reset (synchronous):
  - State returns to IDLE.
  - All outputs go to 0, including the output holding register; the pending word is discarded.
  - The same applies when reset is asserted mid-session: wr_valid is 0 in the cycle after reset is sampled.
- Encoding (bit 31 down to bit 0):
  - R-type: {000000, rs, rt, rd, shamt, funct}.
  - addi: {001000, rs, rt, imm}.
  - lw: {100011, rs, rt, imm}.
  - sw: {101011, rs, rt, imm}.
  - beq: {000100, rs, rt, imm}.
  - j: {000010, target}.
  - Fields not used by a kind are ignored.
- Handshakes:
  - An input beat transfers on in_valid && in_ready.
  - A write transfers on wr_valid && wr_ready.
  - There is one output holding register.
  - Latency: an accepted legal beat appears on wr_valid/wr_data the next cycle.
  - wr_valid, wr_addr and wr_data stay stable until wr_ready.
- Address handling:
  - A session-local counter acc counts accepted legal beats.
  - Each word's wr_addr = start_addr + its index (0-based).
  - wr_addr never wraps.
- in_ready = (state==LOAD) && !finish_pending && (start_addr+acc < DEPTH) && (!wr_valid || wr_ready). Back-to-back throughput is 1 word/cycle while wr_ready=1.
- Illegal kind (6, 7):
  - The beat is consumed (in_ready rules unchanged).
  - It does not load the holding register and does not advance acc.
  - err is set and stays set until the next start.
- States:
  - IDLE:
    - start → LOAD.
    - On entry to LOAD: latch start_addr; clear acc, word_count, err, full.
  - LOAD:
    - finish sets finish_pending.
    - When start_addr+acc reaches DEPTH, set full and stop accepting.
    - → DONE when (finish_pending || full) and the holding register is empty (wr_valid==0 after the last write handshake).
    - start while in LOAD is ignored.
  - DONE:
    - done=1; busy=0; full, err and word_count hold.
    - start → LOAD (new session; re-latch and clear).
    - finish is ignored.
- Simultaneous events:
  - finish with an accepted beat in the same cycle: the beat is kept, and no further beats are accepted.
  - finish in IDLE is ignored.
- Address range: start_addr ≥ DEPTH gives full=1 immediately; the session accepts no words and goes to DONE in the cycle after entering LOAD.

Test Plan:
- Kind sequence: start with start_addr=0, wr_ready=1; send R-type (rs=1, rt=2, rd=3, shamt=0, funct=0x20), addi (rs=0, rt=4, imm=5), lw, sw, beq, j (target=0x0000010); then finish → writes 0x00221820 @0, 0x20040005 @1, and the correct lw/sw/beq/j words @2..5 (j @5 = 0x08000010); done=1, word_count=6.
- Backpressure: hold wr_ready=0 for 3 cycles with in_valid=1 → in_ready=0 after the first accept; wr_data is unchanged throughout; the order is preserved and no word is lost or duplicated.
- Address limit: DEPTH=256, start_addr=254, send 4 beats → only 2 are accepted (addresses 254 and 255); full=1, in_ready=0, then DONE.
- Illegal kind: beats kind=1, 7, 1 → two writes at consecutive addresses; err=1; word_count=2.
- Same-cycle finish and final beat: finish asserted with a beat that is accepted → that word is written, then DONE.
- Reset mid-session: reset with wr_valid=1 → wr_valid=0, busy=0 and state IDLE on the next cycle; a new start session begins at the new start_addr.
